// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg: shared AES constants, state encoding, S-box table and RotWord.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_rcon.sv
// ---------------------------------------------------------------------------
// aes_inv_rcon: round constant indexed backwards from round 10 (step 0).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_inv_rcon (
  input  logic [3:0] round_num,
  output logic [7:0] rcon
);

  always_comb begin
    rcon = 8'h00;
    case (round_num)
      4'd0: rcon = 8'h36;
      4'd1: rcon = 8'h1b;
      4'd2: rcon = 8'h80;
      4'd3: rcon = 8'h40;
      4'd4: rcon = 8'h20;
      4'd5: rcon = 8'h10;
      4'd6: rcon = 8'h08;
      4'd7: rcon = 8'h04;
      4'd8: rcon = 8'h02;
      4'd9: rcon = 8'h01;
      default: rcon = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/aes_sub_word.sv
// ---------------------------------------------------------------------------
// aes_sub_word: four parallel forward S-boxes applied to one 32-bit word.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_sub_word
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] in_word,
  output logic [AES_WORD_W-1:0] out_word
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign out_word[8*g +: 8] = AES_SBOX[in_word[8*g +: 8]];
  end

endmodule

`default_nettype wire

// File: rtl/aes_inv_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_key_sched_ctrl: walks the AES-128 key schedule backwards from the
// round-10 key, presenting round keys 10..0 over a valid/ready handshake.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_inv_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] last_key,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_round,
  output logic             rk_last,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       round_q, round_d;
  logic [3:0]       step_q, step_d;
  logic             done_q, done_d;

  logic [AES_WORD_W-1:0] w0, w1, w2, w3;
  logic [AES_WORD_W-1:0] p0, p1, p2, p3;
  logic [AES_WORD_W-1:0] sub_out;
  logic [7:0]            rcon;
  logic [KEY_W-1:0]      prev_key;

  assign w0 = key_q[KEY_W-1      -: AES_WORD_W];
  assign w1 = key_q[KEY_W-1-32   -: AES_WORD_W];
  assign w2 = key_q[KEY_W-1-64   -: AES_WORD_W];
  assign w3 = key_q[KEY_W-1-96   -: AES_WORD_W];

  // Undo the forward XOR chain first; p3 is the original w3 that fed SubWord.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  aes_sub_word u_sub_word (
    .in_word  (rot_word(p3)),
    .out_word (sub_out)
  );

  aes_inv_rcon u_inv_rcon (
    .round_num (step_q),
    .rcon      (rcon)
  );

  assign p0       = w0 ^ sub_out ^ {rcon, 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    step_d  = step_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          round_d = 4'(NR);
          step_d  = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
            step_d  = step_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= 4'd0;
      step_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = (state_q == EMIT);
  assign busy     = (state_q == EMIT);
  assign rk_data  = key_q;
  assign rk_round = round_q;
  assign rk_last  = (state_q == EMIT) && (round_q == 4'd0);
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_sched_ctrl: directed and random checks of the inverse key
// schedule against an independent forward-expansion model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_inv_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;
  logic         done;

  int tests;
  int fails;

  logic [7:0]   sb_m   [256];
  logic [127:0] exp_rk [11];

  localparam logic [127:0] K0_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K9_FIPS  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_inv_key_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .last_key (last_key),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .rk_last  (rk_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv, t, s;
    inv = 8'h00;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    end
    t = inv; s = inv;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sb_m[r[31:24]], sb_m[r[23:16]], sb_m[r[15:8]], sb_m[r[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_rot(t) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_key(input int r, input logic [127:0] exp_data);
    tests++;
    assert (rk_valid === 1'b1 && rk_round === 4'(r) && rk_data === exp_data &&
            rk_last === (r == 0) && busy === 1'b1 && done === 1'b0)
    else begin
      fails++;
      $error("FAIL key_r%0d: valid=%b round=%0d last=%b busy=%b done=%b data=%h, required round=%0d data=%h",
             r, rk_valid, rk_round, rk_last, busy, done, rk_data, r, exp_data);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    tests++;
    assert (rk_valid === 1'b0 && busy === 1'b0 && rk_last === 1'b0 && done === exp_done)
    else begin
      fails++;
      $error("FAIL %s: valid=%b busy=%b last=%b done=%b, required valid=0 busy=0 last=0 done=%b",
             tag, rk_valid, busy, rk_last, done, exp_done);
    end
  endtask

  task automatic check_zero(input string tag);
    tests++;
    assert (rk_valid === 1'b0 && busy === 1'b0 && rk_last === 1'b0 && done === 1'b0 &&
            rk_data === 128'h0 && rk_round === 4'd0)
    else begin
      fails++;
      $error("FAIL %s: valid=%b busy=%b last=%b done=%b round=%0d data=%h, required all zero",
             tag, rk_valid, busy, rk_last, done, rk_round, rk_data);
    end
  endtask

  // Called at a negedge; returns at the negedge where round 10 must be visible.
  task automatic start_key(input logic [127:0] k);
    start    = 1'b1;
    last_key = k;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic run_keys(input int stall_r, input int poke_r);
    for (int r = 10; r >= 0; r--) begin
      check_key(r, exp_rk[r]);
      if (r == stall_r) begin
        rk_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_key(r, exp_rk[r]);
        end
        rk_ready = 1'b1;
      end
      if (r == poke_r) begin
        start    = 1'b1;
        last_key = ~exp_rk[10];
      end
      @(negedge clk);
      start = 1'b0;
    end
    check_idle("done_pulse", 1'b1);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    last_key = '0;
    rk_ready = 1'b1;
    for (int i = 0; i < 256; i++) sb_m[i] = sbox_calc(8'(i));

    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle_after_reset", 1'b0);

    // FIPS-197 A.1 key, endpoints checked against published values.
    expand(K0_FIPS);
    start_key(K10_FIPS);
    check_key(10, K10_FIPS);
    @(negedge clk);
    check_key(9, K9_FIPS);
    for (int r = 8; r >= 1; r--) begin
      @(negedge clk);
      check_key(r, exp_rk[r]);
    end
    @(negedge clk);
    check_key(0, K0_FIPS);
    @(negedge clk);
    check_idle("fips_done", 1'b1);
    @(negedge clk);
    check_idle("fips_done_clear", 1'b0);

    // Backpressure at round 5, then back-to-back start in the done cycle
    // with a spurious start at round 7 that must be ignored.
    expand({$urandom, $urandom, $urandom, $urandom});
    start_key(exp_rk[10]);
    run_keys(5, -1);
    expand({$urandom, $urandom, $urandom, $urandom});
    start_key(exp_rk[10]);
    run_keys(-1, 7);
    @(negedge clk);
    check_idle("b2b_done_clear", 1'b0);

    // Asynchronous reset mid-sequence at round 4.
    expand({$urandom, $urandom, $urandom, $urandom});
    start_key(exp_rk[10]);
    for (int r = 10; r >= 4; r--) begin
      check_key(r, exp_rk[r]);
      if (r > 4) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    expand({$urandom, $urandom, $urandom, $urandom});
    start_key(exp_rk[10]);
    run_keys(-1, -1);

    for (int n = 0; n < 100; n++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      start_key(exp_rk[10]);
      run_keys(-1, -1);
    end
    @(negedge clk);
    check_idle("final_idle", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
